// File: rtl/lcd_frame_streamer.sv
// Streams one ST7735 frame over SPI mode 0: the CASET/RASET/RAMWR window header, then the
// whole raster as RGB565 words fetched from the renderer through a pixel_req/pixel_in handshake.
`timescale 1ns/1ps
module lcd_frame_streamer #(
  parameter int LCD_W   = 128,
  parameter int LCD_H   = 160,
  parameter int CLK_DIV = 2,
  parameter int X_OFS   = 0,
  parameter int Y_OFS   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [12:0] x,
  output logic [12:0] y,
  output logic        pixel_req,
  input  logic [15:0] pixel_in,
  output logic        lcd_sck,
  output logic        lcd_mosi,
  output logic        lcd_dc,
  output logic        lcd_cs_n
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_PREQ   = 3'd2,
    S_PWAIT  = 3'd3,
    S_PSHIFT = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [7:0]  CMD_CASET = 8'h2A;
  localparam logic [7:0]  CMD_RASET = 8'h2B;
  localparam logic [7:0]  CMD_RAMWR = 8'h2C;
  localparam logic [7:0]  X_OFS_B   = 8'(X_OFS);
  localparam logic [7:0]  X_END_B   = 8'(X_OFS + LCD_W - 1);
  localparam logic [7:0]  Y_OFS_B   = 8'(Y_OFS);
  localparam logic [7:0]  Y_END_B   = 8'(Y_OFS + LCD_H - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [12:0] X_LAST    = 13'(LCD_W - 1);
  localparam logic [12:0] Y_LAST    = 13'(LCD_H - 1);
  localparam logic [3:0]  HDR_LAST  = 4'd10;

  state_e      state_q;
  logic        busy_q;
  logic        done_q;
  logic        preq_q;
  logic        sck_q;
  logic        dc_q;
  logic        cs_n_q;
  logic [12:0] x_q;
  logic [12:0] y_q;
  logic [15:0] shreg_q;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  byte_idx_q;
  logic [7:0]  div_q;

  logic        tick_s;
  logic        bit_end_s;
  logic        word_end_s;
  logic        last_px_s;
  logic [3:0]  bit_last_s;
  logic [3:0]  next_idx_s;
  logic [7:0]  next_byte_s;

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = CMD_CASET;
      4'd2:    b = X_OFS_B;
      4'd4:    b = X_END_B;
      4'd5:    b = CMD_RASET;
      4'd7:    b = Y_OFS_B;
      4'd9:    b = Y_END_B;
      4'd10:   b = CMD_RAMWR;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic hdr_is_data(input logic [3:0] idx);
    return !((idx == 4'd0) || (idx == 4'd5) || (idx == 4'd10));
  endfunction

  // Bit and word boundaries of the serializer shared by header bytes and pixel words
  always_comb begin
    tick_s    = (div_q == DIV_LAST);
    bit_end_s = sck_q && tick_s;
    if (state_q == S_HDR) begin
      bit_last_s = 4'd7;
    end else begin
      bit_last_s = 4'd15;
    end
    word_end_s  = bit_end_s && (bit_cnt_q == bit_last_s);
    last_px_s   = (x_q == X_LAST) && (y_q == Y_LAST);
    next_idx_s  = byte_idx_q + 4'd1;
    next_byte_s = hdr_byte(next_idx_s);
  end

  // Frame sequencer, SPI serializer and raster walker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      preq_q     <= 1'b0;
      sck_q      <= 1'b0;
      dc_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      x_q        <= 13'd0;
      y_q        <= 13'd0;
      shreg_q    <= 16'h0000;
      bit_cnt_q  <= 4'd0;
      byte_idx_q <= 4'd0;
      div_q      <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            byte_idx_q <= 4'd0;
            bit_cnt_q  <= 4'd0;
            div_q      <= 8'd0;
            sck_q      <= 1'b0;
            dc_q       <= 1'b0;
            shreg_q    <= {CMD_CASET, 8'h00};
            state_q    <= S_HDR;
          end
        end
        S_HDR, S_PSHIFT: begin
          if (tick_s) begin
            div_q <= 8'd0;
            sck_q <= ~sck_q;
          end else begin
            div_q <= div_q + 8'd1;
          end
          if (bit_end_s && !word_end_s) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            shreg_q   <= {shreg_q[14:0], 1'b0};
          end
          // Word boundary: SCK is going low here, so dc may change for the next byte
          if (word_end_s) begin
            bit_cnt_q <= 4'd0;
            if (state_q == S_HDR) begin
              if (byte_idx_q == HDR_LAST) begin
                x_q     <= 13'd0;
                y_q     <= 13'd0;
                dc_q    <= 1'b1;
                preq_q  <= 1'b1;
                state_q <= S_PREQ;
              end else begin
                byte_idx_q <= next_idx_s;
                shreg_q    <= {next_byte_s, 8'h00};
                dc_q       <= hdr_is_data(next_idx_s);
              end
            end else begin
              if (x_q == X_LAST) begin
                x_q <= 13'd0;
                y_q <= y_q + 13'd1;
              end else begin
                x_q <= x_q + 13'd1;
              end
              if (last_px_s) begin
                cs_n_q  <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                preq_q  <= 1'b1;
                state_q <= S_PREQ;
              end
            end
          end
        end
        S_PREQ: begin
          preq_q  <= 1'b0;
          state_q <= S_PWAIT;
        end
        S_PWAIT: begin
          shreg_q   <= pixel_in;
          bit_cnt_q <= 4'd0;
          div_q     <= 8'd0;
          state_q   <= S_PSHIFT;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign pixel_req  = preq_q;
  assign x          = x_q;
  assign y          = y_q;
  assign lcd_sck    = sck_q;
  assign lcd_mosi   = shreg_q[15];
  assign lcd_dc     = dc_q;
  assign lcd_cs_n   = cs_n_q;

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Scoreboard bench: a full-size panel at CLK_DIV=2 (header, first pixels, raster wrap, resets)
// and a tiny panel at CLK_DIV=1 with offsets (whole frames, timing, start filtering).
`timescale 1ns/1ps
module tb_lcd_frame_streamer;

  localparam int AW = 128;
  localparam int AH = 160;
  localparam int AD = 2;
  localparam int BW = 4;
  localparam int BH = 3;
  localparam int BD = 1;
  localparam int BXO = 2;
  localparam int BYO = 1;

  typedef struct {
    int          nb;
    logic        dc;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, a_start = 1'b0;
  logic [15:0] a_pix = 16'h0000;
  logic        a_busy, a_done, a_preq, a_sck, a_mosi, a_dc, a_cs_n;
  logic [12:0] a_x, a_y;

  logic        rst_b = 1'b1, b_start = 1'b0;
  logic [15:0] b_pix = 16'h0000;
  logic        b_busy, b_done, b_preq, b_sck, b_mosi, b_dc, b_cs_n;
  logic [12:0] b_x, b_y;

  lcd_frame_streamer #(.LCD_W(AW), .LCD_H(AH), .CLK_DIV(AD), .X_OFS(0), .Y_OFS(0)) dut_a (
    .clk(clk), .reset(rst_a), .start(a_start), .busy(a_busy), .frame_done(a_done),
    .x(a_x), .y(a_y), .pixel_req(a_preq), .pixel_in(a_pix), .lcd_sck(a_sck),
    .lcd_mosi(a_mosi), .lcd_dc(a_dc), .lcd_cs_n(a_cs_n));

  lcd_frame_streamer #(.LCD_W(BW), .LCD_H(BH), .CLK_DIV(BD), .X_OFS(BXO), .Y_OFS(BYO)) dut_b (
    .clk(clk), .reset(rst_b), .start(b_start), .busy(b_busy), .frame_done(b_done),
    .x(b_x), .y(b_y), .pixel_req(b_preq), .pixel_in(b_pix), .lcd_sck(b_sck),
    .lcd_mosi(b_mosi), .lcd_dc(b_dc), .lcd_cs_n(b_cs_n));

  exp_t a_q[$];
  exp_t b_q[$];
  int n_total = 0;
  int n_bad = 0;
  int a_px_cnt = 0, a_words = 0;
  int b_px_cnt = 0, b_words = 0, b_done_cnt = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] hdr_exp(input int i, input int xo, input int w, input int yo, input int h);
    case (i)
      0:       return 8'h2A;
      2:       return 8'(xo);
      4:       return 8'(xo + w - 1);
      5:       return 8'h2B;
      7:       return 8'(yo);
      9:       return 8'(yo + h - 1);
      10:      return 8'h2C;
      default: return 8'h00;
    endcase
  endfunction

  // SPI decoder A: collect bits on rising SCK, compare each finished word with the queue head
  logic [15:0] a_acc = 16'h0000;
  int a_nb = 0;
  logic a_dc0 = 1'b0, a_dc_chg = 1'b0, a_cs_bad = 1'b0;
  always @(posedge a_sck or posedge rst_a) begin
    exp_t e;
    if (rst_a) begin
      a_q.delete();
      a_nb = 0;
      a_words = 0;
    end else begin
      if (a_nb == 0) begin
        a_dc0 = a_dc; a_dc_chg = 1'b0; a_cs_bad = 1'b0;
      end else if (a_dc != a_dc0) begin
        a_dc_chg = 1'b1;
      end
      if (a_cs_n) a_cs_bad = 1'b1;
      a_acc = {a_acc[14:0], a_mosi};
      a_nb++;
      if (a_q.size() == 0) begin
        chk_eq("a_unexpected_bits", 64'(a_q.size()), 64'd1);
        a_nb = 0;
      end else if (a_nb == a_q[0].nb) begin
        e = a_q.pop_front();
        chk_eq("a_word", (e.nb == 8) ? 64'(a_acc[7:0]) : 64'(a_acc), 64'(e.val));
        chk_eq("a_word_dc", {a_dc_chg, a_dc0}, {1'b0, e.dc});
        chk_eq("a_word_cs", 64'(a_cs_bad), 64'd0);
        a_words++;
        a_nb = 0;
      end
    end
  end

  // SPI decoder B
  logic [15:0] b_acc = 16'h0000;
  int b_nb = 0;
  logic b_dc0 = 1'b0, b_dc_chg = 1'b0, b_cs_bad = 1'b0;
  always @(posedge b_sck or posedge rst_b) begin
    exp_t e;
    if (rst_b) begin
      b_q.delete();
      b_nb = 0;
      b_words = 0;
    end else begin
      if (b_nb == 0) begin
        b_dc0 = b_dc; b_dc_chg = 1'b0; b_cs_bad = 1'b0;
      end else if (b_dc != b_dc0) begin
        b_dc_chg = 1'b1;
      end
      if (b_cs_n) b_cs_bad = 1'b1;
      b_acc = {b_acc[14:0], b_mosi};
      b_nb++;
      if (b_q.size() == 0) begin
        chk_eq("b_unexpected_bits", 64'(b_q.size()), 64'd1);
        b_nb = 0;
      end else if (b_nb == b_q[0].nb) begin
        e = b_q.pop_front();
        chk_eq("b_word", (e.nb == 8) ? 64'(b_acc[7:0]) : 64'(b_acc), 64'(e.val));
        chk_eq("b_word_dc", {b_dc_chg, b_dc0}, {1'b0, e.dc});
        chk_eq("b_word_cs", 64'(b_cs_bad), 64'd0);
        b_words++;
        b_nb = 0;
      end
    end
  end

  // Renderer A: answer each pixel_req, check raster position, push expected word
  initial begin : rend_a
    logic [15:0] v;
    int idx;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        a_px_cnt = 0;
        prev = 1'b0;
      end else begin
        if (a_preq) begin
          chk_eq("a_preq_one_cycle", 64'(prev), 64'd0);
          idx = a_px_cnt % (AW * AH);
          chk_eq("a_x", 64'(a_x), 64'(idx % AW));
          chk_eq("a_y", 64'(a_y), 64'(idx / AW));
          chk_eq("a_px_dc_cs", {a_dc, a_cs_n}, 2'b10);
          v = (idx == 0) ? 16'hF800 : 16'($urandom);
          a_pix = v;
          a_q.push_back('{16, 1'b1, v});
          a_px_cnt++;
        end
        prev = a_preq;
      end
    end
  end

  // Renderer B, plus frame_done pulse counter and SCK high-width check
  initial begin : rend_b
    logic [15:0] v;
    int idx;
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        b_px_cnt = 0;
        b_done_cnt = 0;
        run = 0;
      end else begin
        if (b_preq) begin
          idx = b_px_cnt % (BW * BH);
          chk_eq("b_x", 64'(b_x), 64'(idx % BW));
          chk_eq("b_y", 64'(b_y), 64'(idx / BW));
          v = (idx == 0) ? 16'h07E0 : 16'($urandom);
          b_pix = v;
          b_q.push_back('{16, 1'b1, v});
          b_px_cnt++;
        end
        if (b_done) b_done_cnt++;
        if (b_sck) begin
          run++;
        end else begin
          if (run != 0) chk_eq("b_sck_high_clks", 64'(run), 64'(BD));
          run = 0;
        end
      end
    end
  end

  task automatic push_hdr_a();
    for (int i = 0; i < 11; i++)
      a_q.push_back('{8, !(i == 0 || i == 5 || i == 10), {8'h00, hdr_exp(i, 0, AW, 0, AH)}});
  endtask

  task automatic push_hdr_b();
    for (int i = 0; i < 11; i++)
      b_q.push_back('{8, !(i == 0 || i == 5 || i == 10), {8'h00, hdr_exp(i, BXO, BW, BYO, BH)}});
  endtask

  task automatic run_b_frame(input string tag);
    int n;
    bit seen;
    int px0, w0, d0;
    px0 = b_px_cnt; w0 = b_words; d0 = b_done_cnt;
    seen = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    push_hdr_b();
    @(negedge clk);
    b_start = 1'b0;
    for (n = 1; n < 3000; n++) begin
      if (n > 1) @(negedge clk);
      if (b_done) begin
        seen = 1'b1;
        break;
      end
      if (n == 100) b_start = 1'b1;
      if (n == 101) b_start = 1'b0;
    end
    chk_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk_eq({tag, "_len"}, 64'(n), 64'(88 * 2 * BD + BW * BH * (32 * BD + 2) + 1));
    chk_eq({tag, "_end_busy_cs"}, {b_busy, b_cs_n}, 2'b01);
    chk_eq({tag, "_pixels"}, 64'(b_px_cnt - px0), 64'(BW * BH));
    chk_eq({tag, "_words"}, 64'(b_words - w0), 64'(11 + BW * BH));
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (4) @(negedge clk);
    chk_eq({tag, "_start_at_done_ignored"}, {b_busy, b_cs_n}, 2'b01);
    chk_eq({tag, "_done_pulses"}, 64'(b_done_cnt - d0), 64'd1);
    chk_eq({tag, "_queue_empty"}, 64'(b_q.size()), 64'd0);
  endtask

  initial begin : main
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk_eq("a_reset_vals", {a_busy, a_done, a_preq, a_sck, a_mosi, a_dc, a_cs_n, a_x, a_y},
           {7'b0000001, 13'd0, 13'd0});
    chk_eq("b_reset_vals", {b_busy, b_done, b_preq, b_sck, b_mosi, b_dc, b_cs_n, b_x, b_y},
           {7'b0000001, 13'd0, 13'd0});

    // Reset in the middle of the header
    a_start = 1'b1;
    push_hdr_a();
    @(negedge clk);
    a_start = 1'b0;
    repeat (60) @(negedge clk);
    chk_eq("a_hdr_busy_cs", {a_busy, a_cs_n}, 2'b10);
    #2 rst_a = 1'b1;
    #1 chk_eq("a_reset_mid_hdr", {a_cs_n, a_sck, a_busy, a_done, a_preq, a_x, a_y},
              {5'b10000, 13'd0, 13'd0});
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);

    // Header, first pixel, and raster wraps up to row 5
    a_start = 1'b1;
    push_hdr_a();
    @(negedge clk);
    a_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (a_px_cnt >= 645) begin
        ok = 1'b1;
        break;
      end
    end
    chk_eq("a_px_wait", 64'(ok), 64'd1);
    chk_eq("a_words", 64'(a_words), 64'(11 + 644));
    @(negedge clk);
    chk_eq("a_busy_mid_frame", {a_busy, a_cs_n}, 2'b10);
    #2 rst_a = 1'b1;
    #1 chk_eq("a_reset_mid_frame", {a_cs_n, a_busy, a_preq, a_x, a_y}, {3'b100, 13'd0, 13'd0});
    @(negedge clk);
    rst_a = 1'b0;

    // Small panel: whole frames at CLK_DIV=1
    run_b_frame("b_f1");
    run_b_frame("b_f2");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
